// File: rtl/fp_alu_pkg.sv
// Shared types, constants and result classification for the FP ALU sequencer.
// Optional flag logic in fp_op_sequencer is enabled with FP_SEQ_FLAGS_EN.
package fp_alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } seq_state_e;

    localparam logic       OP_ADD       = 1'b0;
    localparam logic       OP_MUL       = 1'b1;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    localparam int FLG_NAN       = 4;
    localparam int FLG_INF       = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_ZERO      = 0;

    // Magnitudes only: sign bits never influence any flag.
    function automatic logic [4:0] classify(
        input logic [30:0] res_mag,
        input logic [30:0] in1_mag,
        input logic [30:0] in2_mag,
        input logic        sel
    );
        logic [4:0] flags;
        logic       exp_max;
        logic       man_nz;
        logic       in1_fin;
        logic       in2_fin;
        flags   = '0;
        exp_max = (res_mag[30:23] == EXP_ALL_ONES);
        man_nz  = (res_mag[22:0] != '0);
        in1_fin = (in1_mag[30:23] != EXP_ALL_ONES);
        in2_fin = (in2_mag[30:23] != EXP_ALL_ONES);
        flags[FLG_NAN]      = exp_max && man_nz;
        flags[FLG_INF]      = exp_max && !man_nz;
        flags[FLG_OVERFLOW] = flags[FLG_INF] && in1_fin && in2_fin;
        flags[FLG_ZERO]     = (res_mag == '0);
        flags[FLG_UNDERFLOW] =
            ((res_mag[30:23] == '0) && man_nz) ||
            (flags[FLG_ZERO] && (sel == OP_MUL) &&
             (in1_mag != '0) && in1_fin && (in2_mag != '0) && in2_fin);
        return flags;
    endfunction

endpackage

// File: rtl/fp_op_sequencer_if.sv
// Operand input stream and result output stream of the FP ALU sequencer.
interface fp_op_sequencer_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            in_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_flags;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_op_fifo.sv
// Synchronous FIFO of {op, a, b} entries with full/empty and async active-low reset.
module fp_op_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fp_op_sequencer.sv
// Buffers operand pairs, drives the combinational FP ALU and captures its result.
// Define FP_SEQ_FLAGS_EN to register classification flags; otherwise out_flags is 0.
module fp_op_sequencer
    import fp_alu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_op_sequencer_if.slave  bus,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    output logic              alu_sel,
    input  logic [XLEN-1:0]   alu_result,
    output logic              busy
);
    localparam int FW    = 2*XLEN + 1;
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    seq_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [FW-1:0]    head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             release_out;
    logic             out_valid_q;
    logic [XLEN-1:0]  out_result_q;

    assign push         = bus.in_valid && !full;
    assign bus.in_ready = !full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign busy = !empty || (state != IDLE);

    fp_op_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({bus.in_op, bus.in_a, bus.in_b}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Handing off a result and issuing the next queued op share one edge.
                if (out_valid_q && bus.out_ready) begin
                    release_out = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        cnt_d   = CNT_W'(SETTLE_CYCLES);
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_sel      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (pop) begin
                alu_sel <= head[2*XLEN];
                alu_in1 <= head[2*XLEN-1:XLEN];
                alu_in2 <= head[XLEN-1:0];
            end
            if (capture) begin
                out_valid_q  <= 1'b1;
                out_result_q <= alu_result;
            end else if (release_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef FP_SEQ_FLAGS_EN
    logic [4:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (capture) begin
            flags_q <= classify(alu_result[30:0], alu_in1[30:0], alu_in2[30:0], alu_sel);
        end
    end

    assign bus.out_flags = flags_q;
`else
    assign bus.out_flags = '0;
`endif

endmodule

// File: doc/fp_op_sequencer.md
# fp_op_sequencer

Sequential front/back end for the combinational floating-point ALU (add/mul, IEEE-754 single). It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It drives the ALU's `in1`/`in2`/`sel` from registers, waits a fixed settle time, then captures `result` together with classification flags into a valid/ready output register. It sits directly upstream of the ALU, feeding it, and directly downstream of it, consuming its result.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 1: cycles between driving ALU inputs and sampling `alu_result`; ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO not full.
- `in_a`  in  XLEN  operand A.
- `in_b`  in  XLEN  operand B.
- `in_op`  in  1  0 = add, 1 = mul.
- `alu_in1`  out  XLEN  registered to ALU `in1`.
- `alu_in2`  out  XLEN  registered to ALU `in2`.
- `alu_sel`  out  1  registered to ALU `sel`.
- `alu_result`  in  XLEN  from ALU `result`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_result`  out  XLEN  captured result.
- `out_flags`  out  5  {nan, inf, overflow, underflow, zero}.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Push on `in_valid && in_ready`. `in_ready = !full`. There is no same-cycle push-through when full, even if a pop occurs that cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the `alu_*` registers, load `cnt = SETTLE_CYCLES`, go to SETTLE.
  - SETTLE: decrement `cnt` each cycle. On the edge where `cnt == 1`, register `alu_result` into `out_result`, compute the flags, set `out_valid`, go to HOLD.
  - HOLD: on `out_valid && out_ready`, clear `out_valid`. If the FIFO is non-empty, pop the next entry into the `alu_*` registers on the same edge and go to SETTLE. Otherwise go to IDLE.
- `alu_*` registers hold their value until the next pop. They are not cleared on IDLE.
- Results are delivered in strict FIFO order. None are dropped or duplicated.
- Flag rules, with e = `result[30:23]`, m = `result[22:0]`, operands taken from the `alu_*` registers:
  - nan: e = FF and m ≠ 0.
  - inf: e = FF and m = 0.
  - overflow: inf, and neither operand has e = FF.
  - zero: `result[30:0] = 0`.
  - underflow: either of:
    - e = 0 and m ≠ 0;
    - zero, and `alu_sel = 1`, and both operands have a nonzero magnitude and e ≠ FF.
- Reset, including mid-operation:
  - All outputs go to 0 except `in_ready`, which goes to 1.
  - FIFO pointers clear, FSM goes to IDLE, `cnt` = 0.
  - In-flight and buffered operations are discarded.

## Timing
- Accept at edge N into an empty, idle block: pop at N+1, capture at N+1+SETTLE_CYCLES, `out_valid` high in the following cycle.
- Steady-state throughput with `out_ready` held at 1 is one result per SETTLE_CYCLES+1 cycles.
- `out_result` and `out_flags` are stable while `out_valid && !out_ready`.
- `in_ready` deasserts in the cycle after the push that fills the FIFO.

## Configuration
- `FP_SEQ_FLAGS_EN` defined: flag logic is compiled in and `out_flags` is registered as specified.
- `FP_SEQ_FLAGS_EN` undefined: `out_flags` is tied to 0. The port remains, and the datapath and timing are unchanged.

## Structure
- Shared package `fp_alu_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, HOLD);
  - `OP_ADD`/`OP_MUL` constants;
  - `EXP_ALL_ONES`;
  - flag bit indices (`FLG_NAN`=4 … `FLG_ZERO`=0);
  - the `classify` function.
- One sub-module: `fp_op_fifo`, a synchronous FIFO of `{op, a, b}` width 2·XLEN+1 with full/empty outputs and the same asynchronous reset.

## Test plan
Bench connects the real FP ALU between `alu_*` and `alu_result`; SETTLE_CYCLES = 1.
- Reset asserted: all outputs 0, `in_ready` = 1, `busy` = 0.
- Add 40400000 + 3FC00000 (3.0 + 1.5) accepted at edge N: `out_valid` high after edge N+2, `out_result` = 40900000, flags = 0.
- Mul 7F7FFFFF × 40000000: `out_result` = 7F800000, inf and overflow set. Mul 7F800000 × 7FC00000: 7FC00000, nan set, overflow clear.
- Mul 00800000 × 00800000: `out_result` = 00000000, underflow and zero set. Add 3F800000 + BF800000: 00000000, zero only.
- Backpressure, FIFO_DEPTH = 4, `out_ready` = 0:
  - five ops are accepted;
  - `in_ready` drops after the fifth push;
  - after releasing `out_ready`, five results emerge in order, one every 2 cycles.
- `rst_n` pulsed low during SETTLE with 3 ops queued:
  - `out_valid` = 0 immediately and `busy` = 0;
  - a subsequent add 3F800000 + 40000000 yields 40400000 with normal latency.
